// File: rtl/cordic_scheduler_q16.sv
// Two-requester scheduler for a shared CORDIC core and its sign handler.
// Requests are granted round-robin. Each granted angle (signed Q16.16
// radians) is reduced to a first-quadrant core angle plus quadrant/sign
// information. The core is started, the sign-handler result is awaited
// (with a timeout), and the response is held until it is accepted.
module cordic_scheduler_q16 #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_angle0,
    input  logic [31:0] req_angle1,
    input  logic [1:0]  req_mode,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        core_start,
    output logic [31:0] core_angle,
    input  logic        core_done,
    output logic [1:0]  sh_kuadran,
    output logic        sh_isNegative,
    output logic        sh_mode,
    input  logic        sh_done,
    input  logic [31:0] sh_result,
    output logic        busy
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    // Angle landmarks in Q16.16, widened to 33 bits so |angle| of the most
    // negative input still compares correctly.
    localparam logic [32:0] HALF_PI       = 33'd102944;
    localparam logic [32:0] PI            = 33'd205887;
    localparam logic [32:0] THREE_HALF_PI = 33'd308831;
    localparam logic [32:0] TWO_PI        = 33'd411775;
    localparam logic [32:0] MOST_NEG_ABS  = 33'h0_8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        START,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              err;
        logic [1:0]        kuadran;
        logic [DATA_W-1:0] angle;
    } reduce_t;

    // Magnitude of a signed Q16.16 angle, computed one bit wider so that
    // 0x80000000 yields +2^31 instead of wrapping.
    function automatic logic [32:0] abs_angle(input logic signed [DATA_W-1:0] angle);
        logic signed [32:0] wide;
        wide = 33'(angle);
        if (wide < 0) begin
            wide = -wide;
        end
        return wide;
    endfunction

    // Quadrant reduction: folds |angle| into [0, pi/2] and reports which
    // quadrant it came from. Anything at or beyond a full turn is an error.
    function automatic reduce_t reduce_angle(input logic signed [DATA_W-1:0] angle);
        reduce_t     r;
        logic [32:0] a;
        logic [32:0] d;
        r = '0;
        d = '0;
        a = abs_angle(angle);
        if (a >= TWO_PI || a == MOST_NEG_ABS) begin
            r.err = 1'b1;
        end else if (a < HALF_PI) begin
            r.kuadran = 2'b00;
            d         = a;
        end else if (a < PI) begin
            r.kuadran = 2'b01;
            d         = PI - a;
        end else if (a < THREE_HALF_PI) begin
            r.kuadran = 2'b10;
            d         = a - PI;
        end else begin
            r.kuadran = 2'b11;
            d         = TWO_PI - a;
        end
        r.angle = d[DATA_W-1:0];
        return r;
    endfunction

    state_t                    state_q;
    state_t                    state_d;
    logic                      rr_ptr;
    logic                      grant_id;
    logic [CNT_W-1:0]          cnt_q;
    logic                      timeout_hit;
    logic signed [DATA_W-1:0]  angle_q;
    logic                      mode_q;
    logic                      id_q;
    reduce_t                   red;
    logic                      unused_core_done;

    // The core's own done level is not needed: completion is signalled by
    // the sign handler further down the chain.
    assign unused_core_done = core_done;

    assign grant_id    = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign red         = reduce_angle(angle_q);
    assign busy        = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the combinational accept and start pulses.
    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Gated by rst_n so no accept is shown while held in reset.
                    req_ready[grant_id] = rst_n;
                    state_d             = REDUCE;
                end
            end
            REDUCE: begin
                state_d = red.err ? RESP : START;
            end
            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (sh_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, round-robin pointer and WAIT timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 1'b0;
            cnt_q   <= '0;
            angle_q <= '0;
            mode_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        angle_q <= grant_id ? req_angle1 : req_angle0;
                        mode_q  <= req_mode[grant_id];
                        id_q    <= grant_id;
                    end
                end
                START: begin
                    cnt_q <= '0;
                end
                WAIT: begin
                    if (!timeout_hit) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // Fairness: the requester not just served gets priority next.
                    if (resp_ready) begin
                        rr_ptr <= ~id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reduced angle and sign-handler controls, held until the next reduction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_angle    <= '0;
            sh_kuadran    <= 2'b00;
            sh_isNegative <= 1'b0;
            sh_mode       <= 1'b0;
        end else if (state_q == REDUCE && !red.err) begin
            core_angle    <= red.angle;
            sh_kuadran    <= red.kuadran;
            sh_isNegative <= angle_q[DATA_W-1];
            sh_mode       <= mode_q;
        end
    end

    // Response registers: loaded on entry to RESP, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                REDUCE: begin
                    if (red.err) begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (sh_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_data  <= sh_result;
                        resp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
